// File: rtl/fare_sum_acc.sv
// ----------------------------------------------------------------------------
// fare_sum_acc
//   Sequential BCD fare accumulator. It sums CHANNELS packed BCD fare
//   components into one DIGITS-wide BCD total, one channel per clock.
//   A per-channel enable mask selects which components are added. A carry out
//   of the top digit saturates the total to all-9s, and that saturation is
//   sticky for the rest of the sum. An enabled channel that holds a non-BCD
//   digit (greater than 9) poisons the whole sum.
//
// Ports
//   clk             in   1                  system clock, rising edge
//   rst             in   1                  synchronous reset, active-high
//   start           in   1                  request a new sum (accepted only when idle)
//   ch_en           in   CHANNELS           channel enable mask, latched with start
//   fare_in_bcd     in   CHANNELS*DIGITS*4  packed channels, channel i at [i*DIGITS*4 +: DIGITS*4]
//   fare_total_bcd  out  DIGITS*4           registered BCD total
//   max             out  1                  total saturated to all-9s
//   err             out  1                  an enabled channel held an invalid digit
//   busy            out  1                  high while accumulating
//   done            out  1                  one-cycle pulse when the result is valid
// ----------------------------------------------------------------------------
module fare_sum_acc #(
    parameter int DIGITS   = 4,
    parameter int CHANNELS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic [CHANNELS*DIGITS*4-1:0] fare_in_bcd,
    output logic [DIGITS*4-1:0]          fare_total_bcd,
    output logic                         max,
    output logic                         err,
    output logic                         busy,
    output logic                         done
);

    localparam int W     = DIGITS * 4;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [W-1:0]     ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                       state;
    logic [CHANNELS*W-1:0]        ch_q;
    logic [CHANNELS-1:0]          en_q;
    logic [W-1:0]                 acc;
    logic [IDX_W-1:0]             idx;
    logic                         sat;
    logic                         bad;

    logic [W-1:0]                 cur_ch;
    logic                         cur_en;
    logic [W:0]                   add_res;
    logic [W-1:0]                 acc_nxt;
    logic                         sat_nxt;

    // Digit-serial BCD add with +6 correction; bit W of the result is the
    // carry out of the most significant digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            s = {1'b0, a[d*4 +: 4]} + {1'b0, b[d*4 +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[d*4 +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    // True when any enabled channel carries a digit outside 0..9.
    // Disabled channels are deliberately not inspected.
    function automatic logic has_bad_digit(input logic [CHANNELS*W-1:0] fares,
                                           input logic [CHANNELS-1:0]   mask);
        logic found;
        found = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (mask[c] && (fares[(c*DIGITS + d)*4 +: 4] > 4'd9)) begin
                    found = 1'b1;
                end
            end
        end
        return found;
    endfunction

    // Select the channel addressed by idx and form the next accumulator value.
    always_comb begin
        cur_ch = '0;
        cur_en = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_ch = ch_q[i*W +: W];
                cur_en = en_q[i];
            end
        end

        add_res = bcd_add(acc, cur_ch);
        acc_nxt = acc;
        sat_nxt = sat;
        if (cur_en && !sat && !bad) begin
            if (add_res[W]) begin
                sat_nxt = 1'b1;
                acc_nxt = ALL_NINES;
            end else begin
                acc_nxt = add_res[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ch_q           <= '0;
            en_q           <= '0;
            acc            <= '0;
            idx            <= '0;
            sat            <= 1'b0;
            bad            <= 1'b0;
            fare_total_bcd <= '0;
            max            <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ch_q  <= fare_in_bcd;
                        en_q  <= ch_en;
                        acc   <= '0;
                        idx   <= '0;
                        sat   <= 1'b0;
                        bad   <= has_bad_digit(fare_in_bcd, ch_en);
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_nxt;
                    sat <= sat_nxt;
                    if (idx == LAST_IDX) begin
                        // Last channel processed this edge: publish the result
                        // from the next-state values, not the stale registers.
                        if (bad) begin
                            fare_total_bcd <= '0;
                            max            <= 1'b0;
                            err            <= 1'b1;
                        end else begin
                            fare_total_bcd <= acc_nxt;
                            max            <= sat_nxt;
                            err            <= 1'b0;
                        end
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
